// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational from the IF PC; EX-stage resolutions train the table and the statistics.
//
// Per-entry counter states:
//   state | meaning
//   SNT   | strongly not-taken
//   WNT   | weakly not-taken (reset value)
//   WT    | weakly taken, predicts taken
//   ST    | strongly taken, predicts taken
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_br,
  input  logic [31:0]      ex_pc,
  input  logic             ex_br,
  input  logic [31:0]      ex_target,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] if_tag;
  logic [TAG_W-1:0] ex_tag;
  logic             if_hit;
  logic             ex_hit;
  logic             upd;
  logic             unused_if_pc_lsb;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[31:IDX_W+2];

  // Instruction PCs are word aligned; the byte offset carries no information.
  assign unused_if_pc_lsb = ^if_pc[1:0];

  // Lookup reads the registered table, so a same-cycle update is seen only next cycle.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = !rst && if_hit && (ctr_q[if_idx] == WT || ctr_q[if_idx] == ST);
  assign pred_target = pred_taken ? target_q[if_idx] : 32'd0;

  assign upd    = ex_valid && ex_is_br;
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  assign mispredict  = upd && ((ex_br != ex_pred_taken) ||
                               (ex_br && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_br ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
      end
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd) begin
        if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
        if (ex_hit) begin
          if (ex_br) begin
            target_q[ex_idx] <= ex_target;
            case (ctr_q[ex_idx])
              SNT: ctr_q[ex_idx] <= WNT;
              WNT: ctr_q[ex_idx] <= WT;
              WT:  ctr_q[ex_idx] <= ST;
              ST:  ctr_q[ex_idx] <= ST;
            endcase
          end else begin
            case (ctr_q[ex_idx])
              SNT: ctr_q[ex_idx] <= SNT;
              WNT: ctr_q[ex_idx] <= SNT;
              WT:  ctr_q[ex_idx] <= WNT;
              ST:  ctr_q[ex_idx] <= WT;
            endcase
          end
        end else if (ex_br) begin
          // Taken miss claims the slot; a not-taken miss leaves any aliasing entry alone.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          ctr_q[ex_idx]    <= WT;
        end
      end
      if (mispredict && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios then random traffic, checked by a
// scoreboard fed from a table-level reference model of the predictor.
module tb_branch_predictor;

  localparam int IDX_W   = 4;
  localparam int CNT_W   = 4;
  localparam int N       = 1 << IDX_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [31:0]      if_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             ex_valid;
  logic             ex_is_br;
  logic [31:0]      ex_pc;
  logic             ex_br;
  logic [31:0]      ex_target;
  logic             ex_pred_taken;
  logic [31:0]      ex_pred_target;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] miss_cnt;

  branch_predictor #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc), .ex_br(ex_br),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] tag;
    logic [31:0] tgt;
    int          ctr;
  } ent_t;

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    int          br;
    int          miss;
  } exp_t;

  ent_t tbl [N];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_br;
  int   m_miss;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic logic [31:0] m_tag(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      tbl[i].v   = 1'b0;
      tbl[i].ctr = 1;
      tbl[i].tag = 32'd0;
      tbl[i].tgt = 32'd0;
    end
    m_br   = 0;
    m_miss = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    int i = m_idx(pc);
    pt  = tbl[i].v && (tbl[i].tag == m_tag(pc)) && (tbl[i].ctr >= 2);
    tgt = pt ? tbl[i].tgt : 32'd0;
  endfunction

  task automatic step(input bit r, input logic [31:0] ipc, input bit v, input bit isb,
                      input logic [31:0] epc, input bit br, input logic [31:0] etgt,
                      input bit ept, input logic [31:0] eptgt);
    exp_t e;
    bit   u;
    int   i;
    @(posedge clk);
    #1;
    rst = r; if_pc = ipc; ex_valid = v; ex_is_br = isb; ex_pc = epc; ex_br = br;
    ex_target = etgt; ex_pred_taken = ept; ex_pred_target = eptgt;

    model_pred(ipc, e.pt, e.ptgt);
    if (r) begin
      e.pt   = 1'b0;
      e.ptgt = 32'd0;
    end
    u      = v && isb;
    e.mp   = u && ((br != ept) || (br && etgt != eptgt));
    e.rpc  = br ? etgt : epc + 32'd4;
    e.br   = m_br;
    e.miss = m_miss;
    sb_q.push_back(e);

    // Advance the model to the state after this cycle's clock edge.
    if (r) begin
      model_reset();
    end else if (u) begin
      i = m_idx(epc);
      if (tbl[i].v && tbl[i].tag == m_tag(epc)) begin
        if (br) begin
          tbl[i].ctr = (tbl[i].ctr < 3) ? tbl[i].ctr + 1 : 3;
          tbl[i].tgt = etgt;
        end else begin
          tbl[i].ctr = (tbl[i].ctr > 0) ? tbl[i].ctr - 1 : 0;
        end
      end else if (br) begin
        tbl[i].v   = 1'b1;
        tbl[i].tag = m_tag(epc);
        tbl[i].tgt = etgt;
        tbl[i].ctr = 2;
      end
      m_br = (m_br < CNT_MAX) ? m_br + 1 : CNT_MAX;
      if (e.mp) m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : CNT_MAX;
    end
  endtask

  task automatic idle(input logic [31:0] ipc);
    step(1'b0, ipc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("pred_taken",  32'(pred_taken),  32'(e.pt));
      chk("pred_target", pred_target,      e.ptgt);
      chk("mispredict",  32'(mispredict),  32'(e.mp));
      chk("redirect_pc", redirect_pc,      e.rpc);
      chk("br_cnt",      32'(br_cnt),      32'(e.br));
      chk("miss_cnt",    32'(miss_cnt),    32'(e.miss));
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    if ($urandom_range(0, 31) == 0) return 32'hFFFF_FFFC;
    pc = (32'($urandom_range(0, 2)) << (IDX_W + 2)) | (32'($urandom_range(0, 3)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(1, 3));
    return pc;
  endfunction

  function automatic logic [31:0] rand_tgt();
    return 32'h1000 + (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r, v, isb, br, ept, mpt;
    logic [31:0] ipc, epc, etgt, eptgt, mtgt;

    rst = 1'b1; if_pc = 32'd0; ex_valid = 1'b0; ex_is_br = 1'b0; ex_pc = 32'd0;
    ex_br = 1'b0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    model_reset();

    step(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(32'h100);

    // Train 0x100 taken to 0x080, then walk the counter through its states.
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'd0);
    idle(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
    idle(32'h100);
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h080, 1'b0, 32'd0);
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h080, 1'b1, 32'h080);
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
    idle(32'h100);

    // Aliasing at the same index.
    step(1'b0, 32'h100, 1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 32'd0);
    idle(32'h100);
    step(1'b0, 32'h140, 1'b1, 1'b1, 32'h180, 1'b0, 32'h500, 1'b0, 32'd0);
    idle(32'h140);
    idle(32'h180);

    // Right direction, wrong target.
    step(1'b0, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h204, 1'b1, 32'h200);
    idle(32'h140);

    // Non-branch and invalid EX slots must not train or count.
    step(1'b0, 32'h140, 1'b1, 1'b0, 32'h140, 1'b1, 32'h999, 1'b0, 32'd0);
    step(1'b0, 32'h140, 1'b0, 1'b1, 32'h140, 1'b1, 32'h888, 1'b0, 32'd0);
    idle(32'h140);

    // Not-taken redirect wraps past the top of the address space.
    step(1'b0, 32'h140, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b1, 32'h10);

    // Mid-run reset overrides a concurrent update.
    step(1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h204, 1'b1, 32'h204);
    idle(32'h140);
    idle(32'h100);

    for (int n = 0; n < 800; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      ipc = rand_pc();
      v   = ($urandom_range(0, 7) != 0);
      isb = ($urandom_range(0, 3) != 0);
      epc = rand_pc();
      br  = $urandom_range(0, 1);
      etgt = rand_tgt();
      model_pred(epc, mpt, mtgt);
      if ($urandom_range(0, 9) < 6) begin
        ept   = mpt;
        eptgt = mtgt;
      end else begin
        ept   = $urandom_range(0, 1);
        eptgt = rand_tgt();
      end
      step(r, ipc, v, isb, epc, br, etgt, ept, eptgt);
    end

    idle(32'h100);
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Front-end counterpart of the EX-stage branch comparator. The comparator resolves conditional branches; this block predicts them at IF and learns from their resolution.
- Direct-mapped BTB with a 2-bit saturating counter per entry.
  - Lookup: combinational from the IF-stage PC.
  - Update: synchronous, driven by the resolved branch outcome at EX.
- Also flags mispredictions, supplies the redirect PC, and keeps saturating statistics counters.

Parameters:
IDX_W, 4, index width; the table has 2**IDX_W entries
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_pc  in  32  PC of the instruction being fetched
pred_taken  out  1  prediction: fetch pred_target next
pred_target  out  32  predicted target; 0 when pred_taken=0
ex_valid  in  1  EX-stage instruction valid (not bubble/flushed)
ex_is_br  in  1  EX instruction is a conditional branch (br_type != 0)
ex_pc  in  32  PC of the EX instruction
ex_br  in  1  resolved outcome from the branch comparator (1 = taken)
ex_target  in  32  computed branch target (pc+imm)
ex_pred_taken  in  1  pred_taken carried down the pipeline for this instruction
ex_pred_target  in  32  pred_target carried down the pipeline
mispredict  out  1  flush IF/ID and redirect fetch
redirect_pc  out  32  correct next PC when mispredict=1
br_cnt  out  CNT_W  branches resolved since reset
miss_cnt  out  CNT_W  mispredictions since reset

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - Each entry holds valid, tag, target[31:0], and ctr[1:0].
- Reset (rst=1 at a clock edge):
  - All valid=0, all ctr=2'b01, br_cnt=0, miss_cnt=0.
  - Outputs while rst is held: pred_taken=0, pred_target=0; mispredict still follows its equation. Reset overrides any update in the same cycle.
  - Reset asserted mid-run clears all learned state in one cycle.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : 0.
- Update qualifier: upd = ex_valid && ex_is_br. When upd=0, the table and counters hold.
- Update on hit (EX pc):
  - ex_br=1: ctr saturating increment, max 2'b11; target <= ex_target.
  - ex_br=0: ctr saturating decrement, min 2'b00; target unchanged.
- Update on miss:
  - ex_br=1: allocate/overwrite the entry with valid=1, tag, target=ex_target, ctr=2'b10.
  - ex_br=0: no allocation; an aliasing entry is left untouched.
- Read/write collision: same index written and read in the same cycle → the lookup sees the pre-update contents. The new contents are visible from the next cycle.
- mispredict (combinational):
  - mispredict = upd && ((ex_br != ex_pred_taken) || (ex_br && ex_target != ex_pred_target)).
- redirect_pc:
  - ex_br ? ex_target : ex_pc + 4, with 32-bit wrap.
  - Value is don't-care when mispredict=0, but must be driven anyway with the same equation.
- Statistics (registered, visible the cycle after the edge):
  - On upd: br_cnt+1, saturating at all-ones.
  - On mispredict: miss_cnt+1, saturating at all-ones.
  - Non-branch or invalid EX instructions do not count.
- Counter state machine per entry:
  - States: SNT=00, WNT=01, WT=10, ST=11.
  - Taken moves toward ST; not-taken moves toward SNT.
  - Predict taken only in WT or ST.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0, br_cnt=0, miss_cnt=0.
- Branch at 0x100 resolves taken to 0x080 with ex_pred_taken=0:
  - Same cycle: mispredict=1, redirect_pc=0x080.
  - Next cycle, if_pc=0x100: pred_taken=1, pred_target=0x080. br_cnt=1, miss_cnt=1.
- Same branch resolves not-taken (ctr 10→01):
  - mispredict=1, redirect_pc=0x104.
  - Next lookup at 0x100: pred_taken=0.
  - Two more taken resolutions (01→10→11), then one not-taken (11→10) → still predicts taken.
- Aliasing: after the 0x100 allocation, a taken branch at 0x140 (same idx, different tag) replaces the entry with ctr=10.
  - Lookup 0x100 → miss, pred_taken=0.
  - A not-taken miss at 0x180 leaves the 0x140 entry intact.
- Correct prediction with a wrong target (ex_pred_taken=1, ex_pred_target=0x200, ex_target=0x204, ex_br=1) → mispredict=1, redirect_pc=0x204, stored target updated.
- Non-branch and invalid EX instructions:
  - ex_valid=1, ex_is_br=0 → no table/counter change, mispredict=0.
  - ex_valid=0, ex_is_br=1 → no table/counter change, mispredict=0.
- Mid-run reset: rst=1 after training → next cycle all lookups miss and counters read 0.
